// File: rtl/secuenciador_medidas_if.sv
// Meter bus and result stream shared by the measurement sequencer.
// The master side is the sequencer; the slave side is the meter plus the readout logic.
interface secuenciador_medidas_if #(
    parameter int OUT_WIDTH = 32,
    parameter int SEL_WIDTH = 4
);
    logic                 meter_enable;
    logic [4:0]           meter_resol;
    logic                 meter_lock;
    logic [OUT_WIDTH-1:0] meter_out;
    logic                 res_valid;
    logic                 res_ready;
    logic [OUT_WIDTH-1:0] res_data;
    logic [SEL_WIDTH-1:0] res_idx;
    logic                 res_err;

    modport master (
        output meter_enable, meter_resol, res_valid, res_data, res_idx, res_err,
        input  meter_lock, meter_out, res_ready
    );

    modport slave (
        input  meter_enable, meter_resol, res_valid, res_data, res_idx, res_err,
        output meter_lock, meter_out, res_ready
    );
endinterface

// File: rtl/secuenciador_medidas.sv
// Measurement sequencer: scans ring oscillators 0..last_idx through the oscillator mux,
// runs one frequency-meter measurement per oscillator and streams each count out.
// A watchdog turns a meter that never locks, or never releases lock, into an error record.
module secuenciador_medidas #(
    parameter int OUT_WIDTH  = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int SETTLE_CYC = 16,
    parameter int TMO_WIDTH  = 24
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [SEL_WIDTH-1:0]   last_idx,
    input  logic [4:0]             resol_in,
    output logic [SEL_WIDTH-1:0]   osc_sel,
    output logic                   busy,
    output logic                   done,
    secuenciador_medidas_if.master bus
);
    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_OUTPUT,
        ST_CLEAR,
        ST_CLEAR_OUT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [SCW-1:0]         settle_cnt;
    logic [TMO_WIDTH-1:0]   wdog;
    logic [SEL_WIDTH-1:0]   osc_sel_q;
    logic [SEL_WIDTH-1:0]   last_idx_q;
    logic [4:0]             resol_q;
    logic [OUT_WIDTH-1:0]   data_q;
    logic [SEL_WIDTH-1:0]   idx_q;
    logic                   err_q;

    logic wdog_max;
    logic last_sel;
    logic load_start;
    logic cap_lock;
    logic cap_tmo;
    logic advance;

    assign wdog_max = &wdog;
    assign last_sel = (osc_sel_q == last_idx_q);

    // State register; reset aborts any scan in progress without emitting a result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode plus single-cycle strobes for the datapath.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        cap_lock   = 1'b0;
        cap_tmo    = 1'b0;
        advance    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_start = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (bus.meter_lock) begin
                    cap_lock = 1'b1;
                    state_d  = ST_OUTPUT;
                end else if (wdog_max) begin
                    cap_tmo = 1'b1;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.res_ready) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (!bus.meter_lock) begin
                    advance = 1'b1;
                    state_d = last_sel ? ST_DONE : ST_SETTLE;
                end else if (wdog_max) begin
                    cap_tmo = 1'b1;
                    state_d = ST_CLEAR_OUT;
                end
            end
            ST_CLEAR_OUT: begin
                if (bus.res_ready) begin
                    advance = 1'b1;
                    state_d = last_sel ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Settle and watchdog counters restart on every state change; the watchdog saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            settle_cnt <= '0;
            wdog       <= '0;
        end else if (state_d != state_q) begin
            settle_cnt <= '0;
            wdog       <= '0;
        end else begin
            if (state_q == ST_SETTLE) settle_cnt <= settle_cnt + SCW'(1);
            if ((state_q == ST_MEASURE || state_q == ST_CLEAR) && !wdog_max)
                wdog <= wdog + TMO_WIDTH'(1);
        end
    end

    // Scan configuration, oscillator select and the captured result record.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            osc_sel_q  <= '0;
            last_idx_q <= '0;
            resol_q    <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (load_start) begin
                last_idx_q <= last_idx;
                resol_q    <= resol_in;
                osc_sel_q  <= '0;
            end
            if (cap_lock) begin
                data_q <= bus.meter_out;
                idx_q  <= osc_sel_q;
                err_q  <= 1'b0;
            end
            if (cap_tmo) begin
                data_q <= '1;
                idx_q  <= osc_sel_q;
                err_q  <= 1'b1;
            end
            if (advance && !last_sel) osc_sel_q <= osc_sel_q + SEL_WIDTH'(1);
        end
    end

    assign osc_sel          = osc_sel_q;
    assign busy             = (state_q != ST_IDLE);
    assign done             = (state_q == ST_DONE);
    assign bus.meter_enable = (state_q == ST_MEASURE);
    assign bus.meter_resol  = resol_q;
    assign bus.res_valid    = (state_q == ST_OUTPUT) || (state_q == ST_CLEAR_OUT);
    assign bus.res_data     = data_q;
    assign bus.res_idx      = idx_q;
    assign bus.res_err      = err_q;
endmodule

// File: tb/tb_secuenciador_medidas.sv
// Directed bench for secuenciador_medidas with a behavioural frequency-meter model
// and a result logger on the valid/ready stream.
module tb_secuenciador_medidas;
    localparam int OW = 32;
    localparam int SW = 4;
    localparam int SC = 16;
    localparam int TW = 8;

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic [SW-1:0] last_idx = '0;
    logic [4:0]    resol_in = '0;
    logic [SW-1:0] osc_sel;
    logic          busy;
    logic          done;

    int n_cmp  = 0;
    int n_fail = 0;

    secuenciador_medidas_if #(.OUT_WIDTH(OW), .SEL_WIDTH(SW)) bus ();

    secuenciador_medidas #(
        .OUT_WIDTH(OW), .SEL_WIDTH(SW), .SETTLE_CYC(SC), .TMO_WIDTH(TW)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .last_idx (last_idx),
        .resol_in (resol_in),
        .osc_sel  (osc_sel),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clock = ~clock;

    // Meter model: lock 100 enabled cycles after enable, count keeps moving while locked,
    // lock released 4 cycles after disable unless this oscillator is the stuck one.
    int lock_delay = 100;
    int never_idx  = -1;
    int stuck_idx  = -1;
    int en_cnt;
    int rel_cnt;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_cnt         <= 0;
            rel_cnt        <= 0;
            bus.meter_lock <= 1'b0;
            bus.meter_out  <= '0;
        end else begin
            if (bus.meter_lock) bus.meter_out <= bus.meter_out + 32'd7;
            if (bus.meter_enable) begin
                rel_cnt <= 0;
                if (!bus.meter_lock) begin
                    if (en_cnt >= lock_delay - 1) begin
                        if (int'(osc_sel) != never_idx) begin
                            bus.meter_lock <= 1'b1;
                            bus.meter_out  <= 32'd1234 + 32'(osc_sel);
                        end
                    end else begin
                        en_cnt <= en_cnt + 1;
                    end
                end
            end else begin
                en_cnt <= 0;
                if (bus.meter_lock && int'(osc_sel) != stuck_idx) begin
                    if (rel_cnt == 3) begin
                        bus.meter_lock <= 1'b0;
                        rel_cnt        <= 0;
                    end else begin
                        rel_cnt <= rel_cnt + 1;
                    end
                end
            end
        end
    end

    // Result logger, done counter and enable-width tracker for oscillator 2.
    logic [OW-1:0] q_data[$];
    logic [SW-1:0] q_idx[$];
    logic          q_err[$];
    int done_count = 0;
    int en_run     = 0;
    int sel2_run   = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            en_run = 0;
        end else begin
            if (bus.res_valid && bus.res_ready) begin
                q_data.push_back(bus.res_data);
                q_idx.push_back(bus.res_idx);
                q_err.push_back(bus.res_err);
            end
            if (done) done_count++;
            if (bus.meter_enable) begin
                en_run++;
            end else if (en_run != 0) begin
                if (osc_sel == 2) sel2_run = en_run;
                en_run = 0;
            end
        end
    end

    task automatic clear_log();
        q_data.delete();
        q_idx.delete();
        q_err.delete();
    endtask

    task automatic pulse_start(input logic [SW-1:0] li, input logic [4:0] r);
        @(posedge clock); #1;
        last_idx = li;
        resol_in = r;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done_count > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.res_ready = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (osc_sel !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_osc_sel: got %0d want 0", osc_sel); end
        n_cmp++; if (bus.meter_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_enable: got %b want 0", bus.meter_enable); end
        n_cmp++; if (bus.meter_resol !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_resol: got %0d want 0", bus.meter_resol); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.res_data !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 0", bus.res_data); end
        n_cmp++; if (bus.res_idx !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.res_idx); end
        n_cmp++; if (bus.res_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", bus.res_err); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_basic_scan();
        int base;
        bit ok;
        clear_log();
        bus.res_ready = 1'b1;
        base = done_count;
        pulse_start(4'd3, 5'd13);
        wait_done(base, 6000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_timeout: done seen %b want 1", ok); end
        repeat (10) @(negedge clock);
        n_cmp++; if (done_count - base !== 1) begin n_fail++; $display("[TB] FAIL basic_done_pulses: got %0d want 1", done_count - base); end
        n_cmp++; if (bus.meter_resol !== 5'd13) begin n_fail++; $display("[TB] FAIL basic_resol: got %0d want 13", bus.meter_resol); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_busy_after: got %b want 0", busy); end
        n_cmp++; if (q_idx.size() !== 4) begin n_fail++; $display("[TB] FAIL basic_count: got %0d want 4", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 4; i++) begin
            n_cmp++;
            if (q_idx[i] !== 4'(i) || q_data[i] !== 32'(1234 + i) || q_err[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL basic_rec%0d: got idx=%0d data=%0d err=%b want idx=%0d data=%0d err=0",
                         i, q_idx[i], q_data[i], q_err[i], i, 1234 + i);
            end
        end
    endtask

    task automatic test_stall();
        int base;
        int stall_n;
        bit ok;
        bit unstable;
        bit stalled;
        logic [OW-1:0] d0;
        clear_log();
        base     = done_count;
        stall_n  = 0;
        unstable = 1'b0;
        stalled  = 1'b0;
        ok       = 1'b0;
        d0       = '0;
        bus.res_ready = 1'b1;
        pulse_start(4'd3, 5'd9);
        for (int c = 0; c < 6000; c++) begin
            @(posedge clock); #1;
            if (bus.res_valid && bus.res_idx == 4'd1 && !stalled) begin
                if (stall_n == 0) d0 = bus.res_data;
                if (bus.res_data !== d0 || bus.res_err !== 1'b0 || bus.meter_enable !== 1'b0) unstable = 1'b1;
                if (stall_n < 50) begin
                    bus.res_ready = 1'b0;
                    stall_n++;
                end else begin
                    bus.res_ready = 1'b1;
                    stalled = 1'b1;
                end
            end
            if (done_count > base) begin
                ok = 1'b1;
                break;
            end
        end
        bus.res_ready = 1'b1;
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL stall_timeout: done seen %b want 1", ok); end
        n_cmp++; if (stall_n !== 50 || !stalled) begin n_fail++; $display("[TB] FAIL stall_held: got %0d stalled cycles want 50", stall_n); end
        n_cmp++; if (unstable) begin n_fail++; $display("[TB] FAIL stall_stable: got unstable=%b want 0", unstable); end
        n_cmp++; if (d0 !== 32'd1235) begin n_fail++; $display("[TB] FAIL stall_data: got %0d want 1235", d0); end
        n_cmp++; if (q_idx.size() !== 4) begin n_fail++; $display("[TB] FAIL stall_count: got %0d want 4", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 4; i++) begin
            n_cmp++;
            if (q_idx[i] !== 4'(i) || q_data[i] !== 32'(1234 + i) || q_err[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_rec%0d: got idx=%0d data=%0d err=%b want idx=%0d data=%0d err=0",
                         i, q_idx[i], q_data[i], q_err[i], i, 1234 + i);
            end
        end
    endtask

    task automatic test_measure_timeout();
        int base;
        bit ok;
        logic [SW-1:0] e_idx[4]  = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [OW-1:0] e_data[4] = '{32'd1234, 32'd1235, 32'hFFFF_FFFF, 32'd1237};
        logic          e_err[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        clear_log();
        never_idx = 2;
        sel2_run  = 0;
        bus.res_ready = 1'b1;
        base = done_count;
        pulse_start(4'd3, 5'd5);
        wait_done(base, 6000, ok);
        never_idx = -1;
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL tmo_timeout: done seen %b want 1", ok); end
        n_cmp++; if (sel2_run < 255 || sel2_run > 256) begin n_fail++; $display("[TB] FAIL tmo_enable_width: got %0d want 255..256", sel2_run); end
        n_cmp++; if (q_idx.size() !== 4) begin n_fail++; $display("[TB] FAIL tmo_count: got %0d want 4", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 4; i++) begin
            n_cmp++;
            if (q_idx[i] !== e_idx[i] || q_data[i] !== e_data[i] || q_err[i] !== e_err[i]) begin
                n_fail++;
                $display("[TB] FAIL tmo_rec%0d: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b",
                         i, q_idx[i], q_data[i], q_err[i], e_idx[i], e_data[i], e_err[i]);
            end
        end
    endtask

    task automatic test_stuck_lock();
        int base;
        bit ok;
        logic [SW-1:0] e_idx[5]  = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3};
        logic [OW-1:0] e_data[5] = '{32'd1234, 32'd1235, 32'hFFFF_FFFF, 32'd1236, 32'd1237};
        logic          e_err[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        clear_log();
        stuck_idx = 1;
        bus.res_ready = 1'b1;
        base = done_count;
        pulse_start(4'd3, 5'd5);
        wait_done(base, 6000, ok);
        stuck_idx = -1;
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL stuck_timeout: done seen %b want 1", ok); end
        n_cmp++; if (q_idx.size() !== 5) begin n_fail++; $display("[TB] FAIL stuck_count: got %0d want 5", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 5; i++) begin
            n_cmp++;
            if (q_idx[i] !== e_idx[i] || q_data[i] !== e_data[i] || q_err[i] !== e_err[i]) begin
                n_fail++;
                $display("[TB] FAIL stuck_rec%0d: got idx=%0d data=%h err=%b want idx=%0d data=%h err=%b",
                         i, q_idx[i], q_data[i], q_err[i], e_idx[i], e_data[i], e_err[i]);
            end
        end
        repeat (10) @(posedge clock);
    endtask

    task automatic test_reset_midscan();
        int base;
        bit ok;
        clear_log();
        bus.res_ready = 1'b1;
        pulse_start(4'd3, 5'd4);
        ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clock); #1;
            if (osc_sel == 4'd2 && bus.meter_enable) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rst_reach_idx2: reached %b want 1", ok); end
        repeat (10) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.meter_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_enable: got %b want 0", bus.meter_enable); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (osc_sel !== 4'd0) begin n_fail++; $display("[TB] FAIL rst_osc_sel: got %0d want 0", osc_sel); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        n_cmp++; if (q_idx.size() !== 2 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_no_result: got %0d records busy=%b want 2 records busy=0", q_idx.size(), busy); end
        clear_log();
        base = done_count;
        pulse_start(4'd1, 5'd4);
        wait_done(base, 6000, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL rst_rescan_timeout: done seen %b want 1", ok); end
        n_cmp++; if (q_idx.size() !== 2) begin n_fail++; $display("[TB] FAIL rst_rescan_count: got %0d want 2", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 2; i++) begin
            n_cmp++;
            if (q_idx[i] !== 4'(i) || q_data[i] !== 32'(1234 + i) || q_err[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL rst_rec%0d: got idx=%0d data=%0d err=%b want idx=%0d data=%0d err=0",
                         i, q_idx[i], q_data[i], q_err[i], i, 1234 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        clear_log();
        bus.res_ready = 1'b1;
        base = done_count;
        pulse_start(4'd15, 5'd21);
        repeat (300) @(posedge clock);
        #1;
        start    = 1'b1;
        last_idx = 4'd2;
        resol_in = 5'd7;
        @(posedge clock); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 8000; c++) begin
            @(posedge clock); #1;
            if (done) begin
                start    = 1'b1;
                last_idx = 4'd1;
                @(posedge clock); #1;
                start = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        n_cmp++; if (!ok) begin n_fail++; $display("[TB] FAIL full_timeout: done seen %b want 1", ok); end
        repeat (20) @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL full_start_on_done: busy=%b want 0", busy); end
        n_cmp++; if (done_count - base !== 1) begin n_fail++; $display("[TB] FAIL full_done_pulses: got %0d want 1", done_count - base); end
        n_cmp++; if (bus.meter_resol !== 5'd21) begin n_fail++; $display("[TB] FAIL full_resol: got %0d want 21", bus.meter_resol); end
        n_cmp++; if (osc_sel !== 4'd15) begin n_fail++; $display("[TB] FAIL full_osc_sel_end: got %0d want 15", osc_sel); end
        n_cmp++; if (q_idx.size() !== 16) begin n_fail++; $display("[TB] FAIL full_count: got %0d want 16", q_idx.size()); end
        for (int i = 0; i < q_idx.size() && i < 16; i++) begin
            n_cmp++;
            if (q_idx[i] !== 4'(i) || q_data[i] !== 32'(1234 + i) || q_err[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL full_rec%0d: got idx=%0d data=%0d err=%b want idx=%0d data=%0d err=0",
                         i, q_idx[i], q_data[i], q_err[i], i, 1234 + i);
            end
        end
    endtask

    initial begin
        bus.res_ready = 1'b1;
        $display("[TB] starting secuenciador_medidas bench");
        test_reset();
        test_basic_scan();
        test_stall();
        test_measure_timeout();
        test_stuck_lock();
        test_reset_midscan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
